// File: rtl/instr_encoder_pkg.sv
// Types and constants shared by the instruction encoder and the decode path.
// The ImmSrc encoding here must stay identical to the one the decoder uses.
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_R = 3'b011,
    IMM_U = 3'b100,
    IMM_J = 3'b101
  } imm_src_e;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } enc_state_e;

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// Combinational packer: scatters immediate bits into an RV32I word and flags
// immediates that are not the exact sign extension of their encodable bits.
module imm_pack
  import instr_encoder_pkg::*;
(
  input  logic [2:0]  imm_src_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] instr_o,
  output logic        illegal_o
);

  logic ext11Ok;
  logic ext12Ok;
  logic ext19Ok;
  logic ext20Ok;

  // Each flag is true when the upper bits are all ones or all zeros.
  assign ext11Ok = (&imm_i[31:11]) || !(|imm_i[31:11]);
  assign ext12Ok = (&imm_i[31:12]) || !(|imm_i[31:12]);
  assign ext19Ok = (&imm_i[31:19]) || !(|imm_i[31:19]);
  assign ext20Ok = (&imm_i[31:20]) || !(|imm_i[31:20]);

  always_comb begin
    instr_o   = NOP_INSTR;
    illegal_o = 1'b0;
    case (imm_src_e'(imm_src_i))
      IMM_I: begin
        instr_o   = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        illegal_o = !ext11Ok;
      end
      IMM_S: begin
        instr_o   = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        illegal_o = !ext11Ok;
      end
      IMM_B: begin
        instr_o   = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                     imm_i[4:1], imm_i[11], opcode_i};
        illegal_o = !ext12Ok || imm_i[0];
      end
      IMM_R: begin
        instr_o   = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
        illegal_o = 1'b0;
      end
      IMM_U: begin
        instr_o   = {imm_i[19:0], rd_i, opcode_i};
        illegal_o = !ext19Ok;
      end
      IMM_J: begin
        instr_o   = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        illegal_o = !ext20Ok || imm_i[0];
      end
      default: begin
        instr_o   = NOP_INSTR;
        illegal_o = 1'b1;
      end
    endcase
    // A bad immediate never leaks a half-encoded word downstream.
    if (illegal_o) begin
      instr_o = NOP_INSTR;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Burst instruction encoder: accepts decoded field bundles, packs them into
// RV32I words and streams them with a running byte address to the loader.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int                Width    = 32,
  parameter logic [Width-1:0]  BASE_RST = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [Width-1:0] base_addr,
  input  logic [15:0]      len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ImmSrc,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [Width-1:0] imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_instr,
  output logic [Width-1:0] out_addr,
  output logic             out_err,
  output logic             busy,
  output logic             done,
  output logic [15:0]      err_count
);

  enc_state_e       state_q, state_d;
  logic [15:0]      remaining_q, remaining_d;
  logic [Width-1:0] addr_q, addr_d;
  logic             out_valid_q, out_valid_d;
  logic [Width-1:0] out_instr_q, out_instr_d;
  logic [Width-1:0] out_addr_q, out_addr_d;
  logic             out_err_q, out_err_d;
  logic [15:0]      err_count_q, err_count_d;

  logic [31:0] packedInstr;
  logic        packedIllegal;
  logic        handshake;

  imm_pack u_imm_pack (
    .imm_src_i (ImmSrc),
    .opcode_i  (opcode),
    .rd_i      (rd),
    .rs1_i     (rs1),
    .rs2_i     (rs2),
    .funct3_i  (funct3),
    .funct7_i  (funct7),
    .imm_i     (imm),
    .instr_o   (packedInstr),
    .illegal_o (packedIllegal)
  );

  assign in_ready  = (state_q == LOAD) && (remaining_q != 16'd0) &&
                     (!out_valid_q || out_ready);
  assign handshake = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    addr_d      = addr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = (len == 16'd0) ? DONE : LOAD;
          addr_d      = base_addr;
          remaining_d = len;
        end
      end
      LOAD: begin
        if (handshake) begin
          remaining_d = remaining_q - 16'd1;
          addr_d      = addr_q + Width'(4);
          if (remaining_q == 16'd1) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // A new burst may only begin once the last word has left the register.
        if (start && !out_valid_q) begin
          state_d     = (len == 16'd0) ? DONE : LOAD;
          addr_d      = base_addr;
          remaining_d = len;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_addr_d  = out_addr_q;
    out_err_d   = out_err_q;
    err_count_d = err_count_q;
    if (handshake) begin
      out_valid_d = 1'b1;
      out_instr_d = packedInstr;
      out_addr_d  = addr_q;
      out_err_d   = packedIllegal;
      if (packedIllegal && (err_count_q != 16'hFFFF)) begin
        err_count_d = err_count_q + 16'd1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= 16'd0;
      addr_q      <= BASE_RST;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_addr_q  <= BASE_RST;
      out_err_q   <= 1'b0;
      err_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      addr_q      <= addr_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_addr_q  <= out_addr_d;
      out_err_q   <= out_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_addr  = out_addr_q;
  assign out_err   = out_err_q;
  assign busy      = (state_q == LOAD);
  assign done      = (state_q == DONE);
  assign err_count = err_count_q;

endmodule
